// File: rtl/calc_host_link.sv
// Host-side link to the UART calculator: turns a binary request into the ASCII
// frame "DDD-DDD-ooo\n", sends it byte by byte, then parses the binary reply.
module calc_host_link #(
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int NUM_W       = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [NUM_W-1:0] cmd_num1,
  input  logic [NUM_W-1:0] cmd_num2,
  input  logic [1:0]       cmd_op,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_done,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  output logic             rsp_valid,
  output logic [15:0]      rsp_result,
  output logic             rsp_err,
  output logic             busy
);

  // Handshake: a request transfers on a cycle where cmd_valid and cmd_ready are
  // both high; cmd_ready is high only in IDLE, so one transaction is in flight.

  typedef enum logic [2:0] {ST_IDLE, ST_CONV, ST_SEND, ST_RSP, ST_DONE} state_t;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [NUM_W-1:0] C100     = NUM_W'(100);
  localparam logic [NUM_W-1:0] C10      = NUM_W'(10);
  localparam logic [NUM_W-1:0] C999     = NUM_W'(999);

  state_t           state;
  logic [7:0]       num1_lo;
  logic [NUM_W-1:0] num2_q;
  logic [1:0]       op_q;
  logic [NUM_W-1:0] rem;
  logic [3:0]       dig_cnt;
  logic             conv_sel;
  logic             conv_tens;
  logic [5:0][3:0]  digits;
  logic [3:0]       byte_idx;
  logic             tx_wait;
  logic [2:0]       rx_idx;
  logic [7:0]       b4;
  logic [7:0]       b5;
  logic [TW-1:0]    tmo_cnt;
  logic [NUM_W-1:0] place;
  logic [7:0]       hdr_exp;

  function automatic logic [7:0] op_char(input logic [1:0] op, input logic [1:0] pos);
    logic [23:0] w;
    case (op)
      2'd0:    w = 24'h616464; // "add"
      2'd1:    w = 24'h737562; // "sub"
      2'd2:    w = 24'h6D756C; // "mul"
      default: w = 24'h646976; // "div"
    endcase
    case (pos)
      2'd0:    return w[23:16];
      2'd1:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                            input logic [5:0][3:0] d,
                                            input logic [1:0] op);
    case (idx)
      4'd0:    return {4'h3, d[0]};
      4'd1:    return {4'h3, d[1]};
      4'd2:    return {4'h3, d[2]};
      4'd3:    return 8'h2D;
      4'd4:    return {4'h3, d[3]};
      4'd5:    return {4'h3, d[4]};
      4'd6:    return {4'h3, d[5]};
      4'd7:    return 8'h2D;
      4'd8:    return op_char(op, 2'd0);
      4'd9:    return op_char(op, 2'd1);
      4'd10:   return op_char(op, 2'd2);
      4'd11:   return 8'h0A;
      default: return 8'h00;
    endcase
  endfunction

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign place     = conv_tens ? C10 : C100;

  always_comb begin
    hdr_exp = 8'h32;
    case (rx_idx)
      3'd1:    hdr_exp = num1_lo;
      3'd2:    hdr_exp = num2_q[7:0];
      3'd3:    hdr_exp = {6'b0, op_q} + 8'd1;
      default: hdr_exp = 8'h32;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      num1_lo    <= '0;
      num2_q     <= '0;
      op_q       <= '0;
      rem        <= '0;
      dig_cnt    <= '0;
      conv_sel   <= 1'b0;
      conv_tens  <= 1'b0;
      digits     <= '0;
      byte_idx   <= '0;
      tx_wait    <= 1'b0;
      rx_idx     <= '0;
      b4         <= '0;
      b5         <= '0;
      tmo_cnt    <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            num1_lo   <= cmd_num1[7:0];
            num2_q    <= cmd_num2;
            op_q      <= cmd_op;
            rem       <= cmd_num1;
            dig_cnt   <= '0;
            conv_sel  <= 1'b0;
            conv_tens <= 1'b0;
            if (cmd_num1 > C999 || cmd_num2 > C999) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_CONV;
            end
          end
        end

        // One subtraction per cycle; the count of subtractions is the digit.
        ST_CONV: begin
          if (rem >= place) begin
            rem     <= rem - place;
            dig_cnt <= dig_cnt + 4'd1;
          end else if (!conv_tens) begin
            if (conv_sel) digits[3] <= dig_cnt;
            else          digits[0] <= dig_cnt;
            conv_tens <= 1'b1;
            dig_cnt   <= '0;
          end else if (!conv_sel) begin
            digits[1] <= dig_cnt;
            digits[2] <= rem[3:0];
            rem       <= num2_q;
            conv_sel  <= 1'b1;
            conv_tens <= 1'b0;
            dig_cnt   <= '0;
          end else begin
            digits[4] <= dig_cnt;
            digits[5] <= rem[3:0];
            byte_idx  <= '0;
            tx_wait   <= 1'b0;
            tmo_cnt   <= '0;
            state     <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (!tx_wait) begin
            tx_start <= 1'b1;
            tx_data  <= frame_byte(byte_idx, digits, op_q);
            tx_wait  <= 1'b1;
          end else if (tx_done) begin
            tx_wait <= 1'b0;
            if (byte_idx == 4'd11) begin
              rx_idx  <= '0;
              tmo_cnt <= TW'(1);
              state   <= ST_RSP;
            end else begin
              byte_idx <= byte_idx + 4'd1;
            end
          end
        end

        // Timeout takes priority over a byte arriving in the same cycle.
        ST_RSP: begin
          if (tmo_cnt == TMO_LAST) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (rx_done) begin
              if (rx_idx < 3'd4) begin
                if (rx_data == hdr_exp) begin
                  rx_idx <= rx_idx + 3'd1;
                end else begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  state     <= ST_DONE;
                end
              end else if (rx_idx == 3'd4) begin
                b4     <= rx_data;
                rx_idx <= 3'd5;
              end else if (rx_idx == 3'd5) begin
                if (rx_data == 8'h0A) begin
                  rsp_valid  <= 1'b1;
                  rsp_err    <= 1'b0;
                  rsp_result <= {8'h00, b4};
                  state      <= ST_DONE;
                end else begin
                  b5     <= rx_data;
                  rx_idx <= 3'd6;
                end
              end else begin
                rsp_valid <= 1'b1;
                state     <= ST_DONE;
                if (rx_data == 8'h0A) begin
                  rsp_err    <= 1'b0;
                  rsp_result <= {b4, b5};
                end else begin
                  rsp_err <= 1'b1;
                end
              end
            end
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
